// File: rtl/uart_pkg.sv
// Shared UART definitions: parity codes, transmitter FSM encoding and baud divisor helper.
// Kept free of tx-specific logic so a receiver can reuse the parity codes.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } uart_state_e;

    // Clock cycles per bit period; integer divide, so the baud rate rounds up slightly.
    function automatic int baud_cnt_max(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; extra pointer MSB distinguishes full from empty.
// Writes at full and reads at empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_fire;
    logic             rd_fire;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte strobes queue in a FIFO and leave on tx as 8N1/8E1/8O1
// frames back-to-back. The FSM state is brought out on state_dbg for checkers.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int UART_BSP   = 9600,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  pi_data,
    input  logic        pi_flag,
    output logic        tx,
    output logic        fifo_full,
    output logic        tx_busy,
    output logic        overflow,
    output uart_state_e state_dbg
);

    localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BSP);
    localparam int BAUD_W       = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CNT_MAX - 1);
    localparam logic STOP_LAST  = (STOP_BITS == 2);

    uart_state_e       state, state_nxt;
    logic [BAUD_W-1:0] baud_cnt, baud_nxt;
    logic [2:0]        bit_cnt, bit_nxt;
    logic              stop_cnt, stop_nxt;
    logic [7:0]        data_reg;
    logic              parity_bit;
    logic              tx_nxt;
    logic              pop;
    logic              baud_done;
    logic [7:0]        fifo_rd_data;
    logic              fifo_empty;

    // pi_flag is a one-cycle write strobe with no ready: a strobe at full is dropped and
    // reported on overflow, even if the FSM pops in that same cycle.
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .wr_en   (pi_flag),
        .wr_data (pi_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign baud_done = (baud_cnt == BAUD_LAST);
    assign tx_busy   = (state != ST_IDLE) || !fifo_empty;
    assign state_dbg = state;

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        stop_nxt  = stop_cnt;
        pop       = 1'b0;
        case (state)
            ST_IDLE: if (!fifo_empty) state_nxt = ST_LOAD;
            ST_LOAD: begin
                pop       = 1'b1;
                state_nxt = ST_START;
                baud_nxt  = '0;
            end
            ST_START: begin
                baud_nxt = baud_cnt + 1'b1;
                if (baud_done) begin
                    state_nxt = ST_DATA;
                    baud_nxt  = '0;
                    bit_nxt   = 3'd0;
                end
            end
            ST_DATA: begin
                baud_nxt = baud_cnt + 1'b1;
                if (baud_done) begin
                    baud_nxt = '0;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        stop_nxt  = 1'b0;
                    end else begin
                        bit_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                baud_nxt = baud_cnt + 1'b1;
                if (baud_done) begin
                    state_nxt = ST_STOP;
                    baud_nxt  = '0;
                    stop_nxt  = 1'b0;
                end
            end
            ST_STOP: begin
                baud_nxt = baud_cnt + 1'b1;
                if (baud_done) begin
                    baud_nxt = '0;
                    if (stop_cnt == STOP_LAST) state_nxt = fifo_empty ? ST_IDLE : ST_LOAD;
                    else                       stop_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // tx is decoded from the next state so the line register changes on the same edge as state.
    always_comb begin
        tx_nxt = 1'b1;
        case (state_nxt)
            ST_START:  tx_nxt = 1'b0;
            ST_DATA:   tx_nxt = data_reg[bit_nxt];
            ST_PARITY: tx_nxt = parity_bit;
            default:   tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            stop_cnt <= 1'b0;
        end else begin
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            stop_cnt <= stop_nxt;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            data_reg   <= 8'h00;
            parity_bit <= 1'b0;
        end else if (state == ST_LOAD) begin
            data_reg   <= fifo_rd_data;
            parity_bit <= (PARITY == PARITY_ODD) ? ~^fifo_rd_data : ^fifo_rd_data;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx       <= 1'b1;
            overflow <= 1'b0;
        end else begin
            tx       <= tx_nxt;
            overflow <= pi_flag && fifo_full;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (8N1, 8E2, 8O1) at 10 clk/bit share one strobe bus;
// the 8N1 instance is tracked by a byte scoreboard.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pi_data = 8'h00;
    logic        pi_flag = 1'b0;
    logic [2:0]  tx_v, full_v, busy_v, ovf_v;
    uart_state_e st_v [3];

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q [$];
    int          ovf_cnt = 0;
    int          mon_sel = 0;
    logic        tx_mon, busy_mon;

    always #10 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_tx_fifo #(
            .UART_BSP   (5_000_000),
            .CLK_FREQ   (50_000_000),
            .FIFO_DEPTH (16),
            .PARITY     ((g == 0) ? 0 : ((g == 1) ? 2 : 1)),
            .STOP_BITS  ((g == 1) ? 2 : 1)
        ) dut (
            .sys_clk   (clk),
            .sys_rst_n (rst_n),
            .pi_data   (pi_data),
            .pi_flag   (pi_flag),
            .tx        (tx_v[g]),
            .fifo_full (full_v[g]),
            .tx_busy   (busy_v[g]),
            .overflow  (ovf_v[g]),
            .state_dbg (st_v[g])
        );
    end

    assign tx_mon   = tx_v[mon_sel];
    assign busy_mon = busy_v[mon_sel];

    always @(negedge clk) if (ovf_v[0]) ovf_cnt++;

    // Called at a negedge; the strobe is sampled by the following posedge.
    task automatic strobe(input logic [7:0] d);
        pi_data = d;
        pi_flag = 1'b1;
        @(negedge clk);
        pi_flag = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_v != 3'b000) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy_v != 3'b000) begin
            errors++;
            $display("FAIL idle_timeout busy=%b required 000", busy_v);
        end
    endtask

    // Waits for a start bit, samples each bit mid-period, returns at the middle of the last stop bit.
    task automatic rx_frame(input int par_en, input int stops, output logic [7:0] d,
                            output logic p, output logic frame_ok, output int span);
        int n = 0;
        d = 8'h00;
        p = 1'b0;
        frame_ok = 1'b1;
        span = 0;
        while (tx_mon !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (tx_mon !== 1'b0) begin
            frame_ok = 1'b0;
            return;
        end
        repeat (5) @(negedge clk);
        span = 5;
        if (tx_mon !== 1'b0) frame_ok = 1'b0;
        for (int b = 0; b < 8; b++) begin
            repeat (10) @(negedge clk);
            span += 10;
            d[b] = tx_mon;
        end
        if (par_en != 0) begin
            repeat (10) @(negedge clk);
            span += 10;
            p = tx_mon;
        end
        for (int s = 0; s < stops; s++) begin
            repeat (10) @(negedge clk);
            span += 10;
            if (tx_mon !== 1'b1) frame_ok = 1'b0;
        end
    endtask

    task automatic tail_len(output int t);
        t = 0;
        while (busy_mon && t < 1000) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic rx_check(input string name);
        logic [7:0] d, e;
        logic p, ok;
        int span;
        rx_frame(0, 1, d, p, ok, span);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (!ok || d !== e) begin
            errors++;
            $display("FAIL %s data=%h framing=%b required data=%h framing=1", name, d, ok, e);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_v[0] !== 1'b1) begin errors++; $display("FAIL reset_tx got %b required 1", tx_v[0]); end
        checks++;
        if (full_v[0] !== 1'b0) begin errors++; $display("FAIL reset_full got %b required 0", full_v[0]); end
        checks++;
        if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy_v[0]); end
        checks++;
        if (ovf_v[0] !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b required 0", ovf_v[0]); end
        checks++;
        if (st_v[0] !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d required %0d", st_v[0], ST_IDLE); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int lat, span, t;
        logic [7:0] d, e;
        logic p, ok;
        mon_sel = 0;
        exp_q.push_back(8'h55);
        strobe(8'h55);
        lat = 1;
        while (tx_mon && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 3) begin errors++; $display("FAIL single_latency got %0d required 3", lat); end
        rx_frame(0, 1, d, p, ok, span);
        e = exp_q.pop_front();
        checks++;
        if (!ok || d !== e) begin errors++; $display("FAIL single_data data=%h framing=%b required %h", d, ok, e); end
        tail_len(t);
        checks++;
        if (span + t != 100) begin errors++; $display("FAIL single_frame_len got %0d required 100", span + t); end
        checks++;
        if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b required 0", busy_v[0]); end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int g;
        mon_sel = 0;
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(8'(i));
            strobe(8'(i));
        end
        for (int i = 0; i < 3; i++) begin
            rx_check("burst_data");
            if (i < 2) begin
                g = 0;
                while (tx_mon && g < 50) begin
                    @(negedge clk);
                    g++;
                end
                checks++;
                if (g != 6) begin errors++; $display("FAIL burst_gap got %0d required 6", g); end
            end
        end
        wait_idle();
    endtask

    task automatic test_fill();
        int ovf_base = ovf_cnt;
        int model_cnt = 0;
        mon_sel = 0;
        fork
            begin
                exp_q.push_back(8'hFF);
                strobe(8'hFF);
                repeat (20) @(negedge clk);
                for (int i = 0; i < 17; i++) begin
                    if (model_cnt < 16) begin
                        exp_q.push_back(8'(i));
                        model_cnt++;
                    end
                    strobe(8'(i));
                    checks++;
                    if (full_v[0] !== (model_cnt == 16)) begin
                        errors++;
                        $display("FAIL fill_full strobe %0d got %b required %b", i, full_v[0], model_cnt == 16);
                    end
                    checks++;
                    if (ovf_v[0] !== (i == 16)) begin
                        errors++;
                        $display("FAIL fill_overflow strobe %0d got %b required %b", i, ovf_v[0], i == 16);
                    end
                end
            end
            begin
                for (int k = 0; k < 17; k++) rx_check("fill_data");
            end
        join
        checks++;
        if (ovf_cnt - ovf_base != 1) begin errors++; $display("FAIL fill_overflow_count got %0d required 1", ovf_cnt - ovf_base); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL fill_leftover got %0d required 0", exp_q.size()); end
        wait_idle();
    endtask

    task automatic test_parity();
        logic [7:0] d;
        logic p, ok, exp_p;
        int span, t, stops, exp_len;
        for (int sel = 1; sel <= 2; sel++) begin
            mon_sel = sel;
            stops   = (sel == 1) ? 2 : 1;
            exp_p   = (sel == 1) ? 1'b1 : 1'b0;
            exp_len = (sel == 1) ? 120 : 110;
            strobe(8'h07);
            rx_frame(1, stops, d, p, ok, span);
            tail_len(t);
            checks++;
            if (!ok || d !== 8'h07) begin errors++; $display("FAIL parity_data sel %0d data=%h framing=%b required 07", sel, d, ok); end
            checks++;
            if (p !== exp_p) begin errors++; $display("FAIL parity_bit sel %0d got %b required %b", sel, p, exp_p); end
            checks++;
            if (span + t != exp_len) begin errors++; $display("FAIL parity_frame_len sel %0d got %0d required %0d", sel, span + t, exp_len); end
            wait_idle();
        end
        mon_sel = 0;
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        int lows = 0;
        mon_sel = 0;
        strobe(8'h3C);
        strobe(8'h99);
        while (tx_mon && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (45) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_v[0] !== 1'b1) begin errors++; $display("FAIL midreset_tx got %b required 1", tx_v[0]); end
        checks++;
        if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b required 0", busy_v[0]); end
        checks++;
        if (st_v[0] !== ST_IDLE) begin errors++; $display("FAIL midreset_state got %0d required %0d", st_v[0], ST_IDLE); end
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_v[0] !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0) begin errors++; $display("FAIL midreset_quiet low_cycles=%0d required 0", lows); end
        exp_q.push_back(8'hA5);
        strobe(8'hA5);
        rx_check("midreset_a5");
        wait_idle();
    endtask

    task automatic test_random();
        int ovf_base = ovf_cnt;
        mon_sel = 0;
        fork
            begin
                for (int i = 0; i < 256; i++) begin
                    logic [7:0] d;
                    d = 8'($urandom_range(0, 255));
                    exp_q.push_back(d);
                    strobe(d);
                    repeat ($urandom_range(100, 139)) @(negedge clk);
                end
            end
            begin
                for (int k = 0; k < 256; k++) rx_check("random_data");
            end
        join
        checks++;
        if (ovf_cnt != ovf_base) begin errors++; $display("FAIL random_overflow got %0d required 0", ovf_cnt - ovf_base); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_parity();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
